// File: rtl/multicycle_controller.sv
// Moore-style control unit for the multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and resolves branches from ALU flags.
module multicycle_controller #(
  parameter logic RESET_PC_WRITE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero_Flag,
  input  logic        Sign_Flag,
  output logic        PC_Write,
  output logic        Adr_Src,
  output logic        Mem_Write,
  output logic        IR_Write,
  output logic        Reg_Write,
  output logic [1:0]  Result_Src,
  output logic [1:0]  ALU_SrcA,
  output logic [1:0]  ALU_SrcB,
  output logic [1:0]  Imm_Src,
  output logic [2:0]  ALU_Control
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0] state_r;
  logic [3:0] state_next_s;
  logic [6:0] op_s;
  logic [2:0] f3_s;
  logic       f7b5_s;
  logic [2:0] funct_alu_s;
  logic       take_s;
  logic       unused_s;

  assign op_s     = Instr[6:0];
  assign f3_s     = Instr[14:12];
  assign f7b5_s   = Instr[30];
  assign unused_s = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // slt/sltu fall back to add; sra/srai are treated as srl.
  function automatic logic [2:0] funct_decode(input logic [2:0] f3, input logic is_sub);
    logic [2:0] alu;
    case (f3)
      3'b000: begin
        if (is_sub) alu = 3'b010;
        else        alu = 3'b000;
      end
      3'b001:  alu = 3'b001;
      3'b100:  alu = 3'b100;
      3'b101:  alu = 3'b101;
      3'b110:  alu = 3'b110;
      3'b111:  alu = 3'b111;
      default: alu = 3'b000;
    endcase
    return alu;
  endfunction

  assign funct_alu_s = funct_decode(f3_s, (op_s == OP_RTYPE) && f7b5_s);

  // blt uses the raw sign of A-B; unknown branch funct3 never takes
  always_comb begin
    case (f3_s)
      3'b000:  take_s = Zero_Flag;
      3'b001:  take_s = ~Zero_Flag;
      3'b100:  take_s = Sign_Flag;
      default: take_s = 1'b0;
    endcase
  end

  // Next-state decode
  always_comb begin
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (op_s)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_RTYPE:          state_next_s = S_EXECR;
          OP_ITYPE:          state_next_s = S_EXECI;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL;
          default:           state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_s == OP_LOAD) state_next_s = S_MEMREAD;
        else                 state_next_s = S_MEMWRITE;
      end
      S_MEMREAD:  state_next_s = S_MEMWB;
      S_MEMWB:    state_next_s = S_FETCH;
      S_MEMWRITE: state_next_s = S_FETCH;
      S_EXECR:    state_next_s = S_ALUWB;
      S_EXECI:    state_next_s = S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BRANCH:   state_next_s = S_FETCH;
      S_JAL:      state_next_s = S_ALUWB;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_next_s;
  end

  // Output decode; everything is held quiet while rst is high
  always_comb begin
    PC_Write    = 1'b0;
    Adr_Src     = 1'b0;
    Mem_Write   = 1'b0;
    IR_Write    = 1'b0;
    Reg_Write   = 1'b0;
    Result_Src  = 2'b00;
    ALU_SrcA    = 2'b00;
    ALU_SrcB    = 2'b00;
    Imm_Src     = 2'b00;
    ALU_Control = 3'b000;
    if (rst) begin
      PC_Write = RESET_PC_WRITE;
    end else begin
      case (state_r)
        S_FETCH: begin
          IR_Write   = 1'b1;
          ALU_SrcB   = 2'b10;
          Result_Src = 2'b10;
          PC_Write   = 1'b1;
        end
        S_DECODE: begin
          ALU_SrcA = 2'b01;
          ALU_SrcB = 2'b01;
          Imm_Src  = 2'b10;
        end
        S_MEMADR: begin
          ALU_SrcA = 2'b10;
          ALU_SrcB = 2'b01;
          if (op_s == OP_STORE) Imm_Src = 2'b01;
          else                  Imm_Src = 2'b00;
        end
        S_MEMREAD: Adr_Src = 1'b1;
        S_MEMWB: begin
          Result_Src = 2'b01;
          Reg_Write  = 1'b1;
        end
        S_MEMWRITE: begin
          Adr_Src   = 1'b1;
          Mem_Write = 1'b1;
        end
        S_EXECR: begin
          ALU_SrcA    = 2'b10;
          ALU_Control = funct_alu_s;
        end
        S_EXECI: begin
          ALU_SrcA    = 2'b10;
          ALU_SrcB    = 2'b01;
          ALU_Control = funct_alu_s;
        end
        S_ALUWB: Reg_Write = 1'b1;
        S_BRANCH: begin
          ALU_SrcA    = 2'b10;
          ALU_Control = 3'b010;
          PC_Write    = take_s;
        end
        S_JAL: begin
          ALU_SrcA = 2'b01;
          ALU_SrcB = 2'b10;
          PC_Write = 1'b1;
        end
        default: PC_Write = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the 3-bit `ALU_Control` code consumed by the shared ALU and reads back that ALU's `Zero_Flag`/`Sign_Flag` to resolve branches. It sits between the instruction register and the datapath muxes, register file and unified memory.

## Interface
Parameters:
- `RESET_PC_WRITE`, 0: value of `PC_Write` while `rst` is high. Fixed at 0 for this design.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `Instr`  in  32  current instruction register contents. Valid from the cycle after FETCH.
- `Zero_Flag`  in  1  ALU result == 0.
- `Sign_Flag`  in  1  ALU result bit 31.
- `PC_Write`  out  1  PC register load enable.
- `Adr_Src`  out  1  memory address select: 0 = PC, 1 = ALU_Out.
- `Mem_Write`  out  1  data memory write enable.
- `IR_Write`  out  1  instruction register and OldPC load enable.
- `Reg_Write`  out  1  register file write enable.
- `Result_Src`  out  2  result mux select: 00 = ALU_Out, 01 = Data, 10 = ALU_Result.
- `ALU_SrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALU_SrcB`  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = const 4.
- `Imm_Src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALU_Control`  out  3  ALU operation code: 000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and.

## Operation
- Moore FSM. All outputs are a function of the state register and the `Instr` fields `op = Instr[6:0]`, `f3 = Instr[14:12]`, `f7b5 = Instr[30]`. Outputs not listed for a state are 0.
- FETCH: `Adr_Src`=0, `IR_Write`=1, `ALU_SrcA`=00, `ALU_SrcB`=10, add, `Result_Src`=10, `PC_Write`=1. Next state: DECODE.
- DECODE: `ALU_SrcA`=01, `ALU_SrcB`=01, `Imm_Src`=10, add (computes branch target). Next state by `op`:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH, with no architectural write.
- MEMADR: `ALU_SrcA`=10, `ALU_SrcB`=01, add. `Imm_Src` is 01 for stores, 00 for loads. Next state: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: `Result_Src`=00, `Adr_Src`=1. Next state: MEMWB.
- MEMWB: `Result_Src`=01, `Reg_Write`=1. Next state: FETCH.
- MEMWRITE: `Result_Src`=00, `Adr_Src`=1, `Mem_Write`=1. Next state: FETCH.
- EXECR: `ALU_SrcA`=10, `ALU_SrcB`=00, funct decode. Next state: ALUWB.
- EXECI: `ALU_SrcA`=10, `ALU_SrcB`=01, `Imm_Src`=00, funct decode. Next state: ALUWB.
- ALUWB: `Result_Src`=00, `Reg_Write`=1. Next state: FETCH.
- BRANCH: `ALU_SrcA`=10, `ALU_SrcB`=00, sub, `Result_Src`=00. `PC_Write` = take. Next state: FETCH.
  - take is `Zero_Flag` for f3=000 (beq), `~Zero_Flag` for f3=001 (bne), `Sign_Flag` for f3=100 (blt).
  - Any other f3: take = 0.
  - blt uses the raw sign of A−B with no overflow correction.
- JAL: `ALU_SrcA`=01, `ALU_SrcB`=10, add, `Result_Src`=00, `PC_Write`=1. Next state: ALUWB (writes PC+4 to rd).
- Funct decode, by f3:
  - 000 → sub (010) if R-type and f7b5=1, else add (000).
  - 001 → 001, 100 → 100, 101 → 101, 110 → 110, 111 → 111.
  - f3 = 010/011 (slt/sltu): unsupported, emit 000.
  - srai/sra: not supported, emit 101.

## Timing
- Synchronous reset: on a `clk` edge with `rst`=1, state ← FETCH. While `rst` is high, all enables (`PC_Write`, `IR_Write`, `Reg_Write`, `Mem_Write`) are forced to 0, and selects and `ALU_Control` are 000/00.
- Reset mid-instruction aborts it. No write enable asserts in the reset cycle or on the edge it is sampled.
- The first FETCH is the cycle after `rst` falls.
- Cycle counts, FETCH to next FETCH:
  - branch 3
  - R-type, I-ALU, store, jal: 4
  - load: 5
  - unsupported opcode: 2
- Flags are sampled combinationally in BRANCH only, and are valid in that same cycle.

## Test plan
- Reset → `rst`=1 for 2 cycles mid-EXECR → state FETCH, `Reg_Write`=0 throughout, first `IR_Write`=1 one cycle after release.
- `Instr`=0x40208033 (sub x0,x1,x2) → sequence FETCH, DECODE, EXECR (`ALU_Control`=010), ALUWB (`Reg_Write`=1), FETCH.
- `Instr`=0x0000A083 (lw) → 5 cycles, `Adr_Src`=1 in MEMREAD, `Result_Src`=01 with `Reg_Write`=1 in MEMWB.
- beq, `Zero_Flag`=1 → `PC_Write`=1 in BRANCH. Same with `Zero_Flag`=0 → `PC_Write`=0. bne inverts. blt with `Sign_Flag`=1 → taken.
- `Instr`=0x0040006F (jal) → JAL with `ALU_SrcA`=01, `ALU_SrcB`=10, `PC_Write`=1, then ALUWB with `Reg_Write`=1.
- `Instr` op=0000000 → DECODE→FETCH, no write enable ever asserted.
